// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared address map, region type and decode helpers for the
//               MMIO hub.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Base byte addresses of each device; only bits [31:3] take part in decode
    localparam logic [31:0] c_SERIAL_ADDR = 32'ha000_03f8;
    localparam logic [31:0] c_RTC_ADDR    = 32'ha000_0048;
    localparam logic [31:0] c_KBD_ADDR    = 32'ha000_0060;
    localparam logic [31:0] c_VGACTL_ADDR = 32'ha000_0100;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        SERIAL = 3'd1,
        RTC    = 3'd2,
        KBD    = 3'd3,
        VGACTL = 3'd4
    } region_t;

    // Map an 8-byte word address onto the device it selects
    function automatic region_t decode_region(input logic [28:0] word);
        region_t r;
        r = NONE;
        if (word == c_SERIAL_ADDR[31:3]) begin
            r = SERIAL;
        end else if (word == c_RTC_ADDR[31:3]) begin
            r = RTC;
        end else if (word == c_KBD_ADDR[31:3]) begin
            r = KBD;
        end else if (word == c_VGACTL_ADDR[31:3]) begin
            r = VGACTL;
        end
        return r;
    endfunction

    // Expand byte enables into a 64-bit lane mask
    function automatic logic [63:0] be_to_mask(input logic [7:0] be);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmio_fifo
// Description : Synchronous first-word fall-through FIFO. The head entry is
//               visible on o_head whenever o_empty is low. Pushes while full
//               and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer and occupancy tracking; a simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (c_AW + 1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (c_AW + 1)'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_hub.sv
`default_nettype none
// ============================================================================
// Module      : mmio_hub
// Description : Memory-mapped device hub with serial TX FIFO, microsecond RTC
//               with atomic 64-bit read, keyboard FIFO and VGA control
//               register. One request per cycle, response one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int SERIAL_DEPTH = 16,
    parameter int KBD_DEPTH    = 8,
    parameter int RTC_DIV      = 50,
    parameter int FB_W         = 400,
    parameter int FB_H         = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_be,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        kbd_valid,
    input  logic [31:0] kbd_code,
    output logic        kbd_ready,
    output logic        vga_sync
);

    localparam int          c_DIV_W    = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RTC_DIV - 1);
    localparam logic [31:0] c_VGA_INFO = 32'((FB_W << 16) | FB_H);

    region_t     w_region;
    logic        w_accept;
    logic        w_rd;
    logic        w_wr;
    logic [63:0] w_rdata;
    logic        w_err;

    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic [7:0]  w_tx_byte;
    logic [7:0]  w_tx_head;

    logic        w_kbd_full;
    logic        w_kbd_empty;
    logic        w_kbd_push;
    logic        w_kbd_pop;
    logic [31:0] w_kbd_head;

    logic [c_DIV_W-1:0] r_div;
    logic [63:0] r_rtc;
    logic [63:0] r_snap;
    logic        r_rsp_valid;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_vga_sync;

    assign w_region = decode_region(req_addr[31:3]);

    // Only a serial write that would overflow the TX FIFO is back-pressured
    assign req_ready = rst | ~((w_region == SERIAL) & req_wen & w_tx_full);
    assign w_accept  = req_valid & req_ready & ~rst;
    assign w_rd      = w_accept & ~req_wen;
    assign w_wr      = w_accept & req_wen;

    assign w_tx_push = w_wr & (w_region == SERIAL) & (|req_be);
    assign tx_valid  = ~w_tx_empty & ~rst;
    assign tx_data   = rst ? 8'd0 : w_tx_head;
    assign w_tx_pop  = tx_valid & tx_ready;

    assign kbd_ready  = rst | ~w_kbd_full;
    assign w_kbd_push = kbd_valid & ~w_kbd_full;
    assign w_kbd_pop  = w_rd & (w_region == KBD);

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign vga_sync  = r_vga_sync;

    // Pick the byte on the lowest enabled lane for a serial write
    always_comb begin
        w_tx_byte = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_be[i]) begin
                w_tx_byte = req_wdata[i*8 +: 8];
            end
        end
    end

    // Unmasked read data and error flag for the addressed device
    always_comb begin
        w_rdata = 64'd0;
        w_err   = 1'b0;
        unique case (w_region)
            RTC: begin
                if (!req_wen) begin
                    if (|req_be[3:0]) begin
                        w_rdata = r_rtc;
                    end else begin
                        w_rdata = {r_snap[63:32], 32'd0};
                    end
                end
            end
            KBD: begin
                if (!req_wen && !w_kbd_empty) begin
                    w_rdata = {32'd0, w_kbd_head};
                end
            end
            VGACTL: begin
                if (!req_wen) begin
                    w_rdata = {32'd0, c_VGA_INFO};
                end
            end
            SERIAL: begin
                w_rdata = 64'd0;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Microsecond divider, live counter and high-half snapshot for atomic reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_rtc  <= 64'd0;
            r_snap <= 64'd0;
        end else begin
            if (r_div == c_DIV_LAST) begin
                r_div <= '0;
                r_rtc <= r_rtc + 64'd1;
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end
            if (w_rd && (w_region == RTC) && (|req_be[3:0])) begin
                r_snap <= r_rtc;
            end
        end
    end

    // Response stage and VGA sync pulse, both one cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
            r_vga_sync  <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_rdata <= w_accept ? (w_rdata & be_to_mask(req_be)) : 64'd0;
            r_rsp_err   <= w_accept & w_err;
            r_vga_sync  <= w_wr & (w_region == VGACTL) & req_be[4] & req_wdata[32];
        end
    end

    mmio_fifo #(
        .WIDTH (8),
        .DEPTH (SERIAL_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_tx_push),
        .i_push_data (w_tx_byte),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty)
    );

    mmio_fifo #(
        .WIDTH (32),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_kbd_push),
        .i_push_data (kbd_code),
        .i_pop       (w_kbd_pop),
        .o_head      (w_kbd_head),
        .o_full      (w_kbd_full),
        .o_empty     (w_kbd_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_mmio_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_hub
// Description : Directed self-checking bench for mmio_hub (RTC_DIV = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_hub;

    localparam logic [31:0] c_SER = 32'ha000_03f8;
    localparam logic [31:0] c_RTC = 32'ha000_0048;
    localparam logic [31:0] c_KBD = 32'ha000_0060;
    localparam logic [31:0] c_VGA = 32'ha000_0100;
    localparam logic [31:0] c_BAD = 32'ha000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_be = 8'd0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        kbd_valid = 1'b0;
    logic [31:0] kbd_code = 32'd0;
    logic        kbd_ready;
    logic        vga_sync;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        s_valid;
    logic [63:0] s_rdata;
    logic        s_err;

    always #5 clk = ~clk;

    mmio_hub #(
        .SERIAL_DEPTH (16),
        .KBD_DEPTH    (8),
        .RTC_DIV      (2),
        .FB_W         (400),
        .FB_H         (300)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .kbd_ready (kbd_ready),
        .vga_sync  (vga_sync)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // One request: driven after a falling edge, sampled 1 time unit after acceptance
    task automatic issue(input logic [31:0] addr, input logic wen,
                         input logic [63:0] wdata, input logic [7:0] be);
        int waited;
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_be    = be;
        #1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            s_valid = 1'b0;
            s_rdata = 64'd0;
            s_err = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid   = rsp_valid;
        s_rdata   = rsp_rdata;
        s_err     = rsp_err;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_be    = 8'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        kbd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_kbd_ready", 64'(kbd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_vga_sync", 64'(vga_sync), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // RTC: 10 edges after reset at DIV=2 -> 5
        repeat (10) @(posedge clk);
        issue(c_RTC, 1'b0, 64'd0, 8'h0f);
        check("rtc_low_valid", 64'(s_valid), 64'd1);
        check("rtc_low_5", s_rdata, 64'd5);
        repeat (100) @(posedge clk);
        issue(c_RTC, 1'b0, 64'd0, 8'hf0);
        check("rtc_high_snap", s_rdata, 64'd0);
        issue(c_RTC, 1'b0, 64'd0, 8'hff);
        check("rtc_full_live", s_rdata, 64'd56);
        issue(c_RTC, 1'b1, 64'hffff_ffff_ffff_ffff, 8'hff);
        check("rtc_wr_err", 64'(s_err), 64'd0);
        check("rtc_wr_rdata", s_rdata, 64'd0);

        // Serial: lowest enabled lane, FWFT head, one-cycle response
        do_reset();
        tx_ready = 1'b1;
        issue(c_SER, 1'b1, 64'h0000_0000_0000_0041, 8'h01);
        check("ser1_valid", 64'(s_valid), 64'd1);
        check("ser1_rdata", s_rdata, 64'd0);
        check("ser1_err", 64'(s_err), 64'd0);
        check("ser1_tx_valid", 64'(tx_valid), 64'd1);
        check("ser1_tx_data", 64'(tx_data), 64'h41);
        @(posedge clk);
        #1;
        check("ser1_rsp_once", 64'(rsp_valid), 64'd0);
        check("ser1_popped", 64'(tx_valid), 64'd0);
        issue(c_SER, 1'b1, 64'h0000_0000_0042_0000, 8'h04);
        check("ser2_tx_data", 64'(tx_data), 64'h42);
        issue(c_SER, 1'b1, 64'h0000_0000_0000_00ff, 8'h00);
        check("ser_be0_nopush", 64'(tx_valid), 64'd0);
        issue(c_SER, 1'b0, 64'd0, 8'hff);
        check("ser_read_zero", s_rdata, 64'd0);

        // Serial back-pressure: 16 fill the FIFO, the 17th waits
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            issue(c_SER, 1'b1, {56'd0, 8'(8'h10 + i)}, 8'h01);
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = c_SER;
        req_wen   = 1'b1;
        req_wdata = 64'h00ee;
        req_be    = 8'h01;
        #1;
        check("full_ready_low", 64'(req_ready), 64'd0);
        check("full_head", 64'(tx_data), 64'h10);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("full_ready_back", 64'(req_ready), 64'd1);
        check("full_head_next", 64'(tx_data), 64'h11);
        check("full_not_yet", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("full_17th_acc", 64'(rsp_valid), 64'd1);
        req_valid = 1'b0;
        tx_ready = 1'b0;

        // Keyboard FIFO
        do_reset();
        kbd_valid = 1'b1;
        kbd_code  = 32'h0000_8001;
        @(negedge clk);
        kbd_code  = 32'h0000_0002;
        @(negedge clk);
        kbd_valid = 1'b0;
        issue(c_KBD, 1'b0, 64'd0, 8'h0f);
        check("kbd_rd1", s_rdata, 64'h8001);
        issue(c_KBD, 1'b0, 64'd0, 8'h0f);
        check("kbd_rd2", s_rdata, 64'h0002);
        issue(c_KBD, 1'b0, 64'd0, 8'h0f);
        check("kbd_rd_empty", s_rdata, 64'd0);
        kbd_valid = 1'b1;
        kbd_code  = 32'h0000_1234;
        issue(c_KBD, 1'b0, 64'd0, 8'h0f);
        kbd_valid = 1'b0;
        check("kbd_push_rd_empty", s_rdata, 64'd0);
        issue(c_KBD, 1'b0, 64'd0, 8'h0f);
        check("kbd_push_stored", s_rdata, 64'h1234);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            kbd_valid = 1'b1;
            kbd_code  = 32'h100 + 32'(i);
        end
        @(negedge clk);
        kbd_valid = 1'b0;
        #1;
        check("kbd_full_ready", 64'(kbd_ready), 64'd0);
        issue(c_KBD, 1'b0, 64'd0, 8'hff);
        check("kbd_full_head", s_rdata, 64'h100);
        check("kbd_ready_back", 64'(kbd_ready), 64'd1);

        // VGA control
        issue(c_VGA, 1'b0, 64'd0, 8'hff);
        check("vga_info", s_rdata, 64'h0000_0000_0190_012c);
        issue(c_VGA, 1'b0, 64'd0, 8'h03);
        check("vga_masked", s_rdata, 64'h0000_0000_0000_012c);
        issue(c_VGA, 1'b1, 64'h0000_0001_0000_0000, 8'h10);
        check("vga_sync_pulse", 64'(vga_sync), 64'd1);
        @(posedge clk);
        #1;
        check("vga_sync_once", 64'(vga_sync), 64'd0);
        issue(c_VGA, 1'b1, 64'h0000_0001_0000_0000, 8'h01);
        check("vga_sync_be_off", 64'(vga_sync), 64'd0);

        // Unmapped
        issue(c_BAD, 1'b0, 64'd0, 8'hff);
        check("bad_err", 64'(s_err), 64'd1);
        check("bad_rdata", s_rdata, 64'd0);
        check("bad_valid", 64'(s_valid), 64'd1);

        // Reset in the same cycle as an accepted request drops the response
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = c_VGA;
        req_wen   = 1'b0;
        req_be    = 8'hff;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop_valid", 64'(rsp_valid), 64'd0);
        check("rst_drop_rdata", rsp_rdata, 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_drop_after", 64'(rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 SHALL have parameters: SERIAL_DEPTH, 16, TX FIFO entries (power of 2); KBD_DEPTH, 8, key FIFO entries (power of 2); RTC_DIV, 50, clk cycles per microsecond tick; FB_W, 400, screen width; FB_H, 300, screen height.
REQ-002 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when both valid and ready are high.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wen  in  1  1 = write, 0 = read.
REQ-009 req_wdata  in  64  lane-aligned write data.
REQ-010 req_be  in  8  active-high byte enables.
REQ-011 rsp_valid  out  1  one-cycle response strobe.
REQ-012 rsp_rdata  out  64  lane-aligned read data.
REQ-013 rsp_err  out  1  unmapped address.
REQ-014 tx_valid, tx_data[7:0] out; tx_ready in: serial drain handshake.
REQ-015 kbd_valid, kbd_code[31:0] in; kbd_ready out: keyboard push handshake.
REQ-016 vga_sync  out  1  one-cycle frame-sync pulse.

Function
REQ-017 Decode SHALL use req_addr[31:3] against 8-byte words: SERIAL 0xa00003f8, RTC 0xa0000048, KBD 0xa0000060, VGACTL 0xa0000100; anything else is unmapped.
REQ-018 req_ready SHALL be 0 only for a serial write while the TX FIFO is full; otherwise it is 1, so back-to-back requests are accepted.
REQ-019 A request accepted in cycle N SHALL produce rsp_valid=1 in cycle N+1 only; writes also respond, with rsp_rdata=0.
REQ-020 An unmapped access SHALL respond with rsp_err=1 and rsp_rdata=0, with no side effects.
REQ-021 A serial write SHALL push the byte on the lowest enabled lane; req_be=0 pushes nothing.
REQ-022 A serial read SHALL return 0.
REQ-023 tx_valid SHALL equal TX FIFO non-empty, and tx_data SHALL be the FIFO head (first-word fall-through); the FIFO pops on tx_valid and tx_ready.
REQ-024 The RTC SHALL be a 64-bit microsecond counter incremented once every RTC_DIV cycles.
REQ-025 An RTC read with any of be[3:0] set SHALL snapshot the full counter and return the live value.
REQ-026 An RTC read with only be[7:4] set SHALL return the snapshot high half in lanes 7:4, so a low-then-high read is atomic.
REQ-027 A KBD read SHALL return the FIFO head in bits 31:0 and pop it; a read while empty returns 0.
REQ-028 kbd_ready SHALL equal KBD FIFO not full.
REQ-029 A KBD push and pop in the same cycle SHALL leave the count unchanged; a push into an empty FIFO plus a read in the same cycle returns 0 and stores the key.
REQ-030 A VGACTL read SHALL return {32'd0 in bits 63:32, (FB_W<<16)|FB_H in bits 31:0}.
REQ-031 A VGACTL write with be[4]=1 and wdata[32]=1 SHALL pulse vga_sync in cycle N+1.
REQ-032 Writes to RTC or KBD SHALL be ignored with rsp_err=0.
REQ-033 Read data SHALL be masked by req_be, so disabled lanes read 0.

Reset
REQ-034 Under rst, all outputs SHALL be 0 except req_ready=1 and kbd_ready=1.
REQ-035 Under rst, both FIFOs, the RTC counter, the divider and the snapshot SHALL clear.
REQ-036 A response pending when rst asserts SHALL be dropped.

Structure
REQ-037 Package mmio_pkg SHALL hold the four address constants, a region enum (NONE, SERIAL, RTC, KBD, VGACTL) and a word-decode function.
REQ-038 Sub-module mmio_fifo (WIDTH, DEPTH; first-word fall-through; full/empty) SHALL be instantiated twice.

Verification
REQ-039 Write 0x41 with be=0x01, then 0x42 with be=0x04 and wdata[23:16]=0x42, to 0xa00003f8, with tx_ready=1 -> tx_data 0x41 then 0x42, each rsp_valid one cycle after acceptance.
REQ-040 Hold tx_ready=0 and issue 17 serial writes -> req_ready=0 on the 17th; raise tx_ready -> the 17th is accepted the next cycle.
REQ-041 RTC_DIV=2 and run 10 cycles -> low read returns 5; stall 100 cycles, then high-only read -> snapshot high half, unchanged.
REQ-042 Push keys 0x8001 and 0x0002, then read 0xa0000060 three times -> 0x8001, 0x0002, 0.
REQ-043 Read 0xa0000100 with be=0xff -> 0x0000_0000_0190_012c; write wdata[32]=1 with be=0x10 -> vga_sync pulses once.
REQ-044 Read 0xa0000200 -> rsp_err=1 and rsp_rdata=0; assert rst in the same cycle as an accepted request -> no rsp_valid.
